int_to_float_iter: RTL and testbench

//   Iterative signed 32-bit integer -> IEEE-754 single converter (cvt.s.w path).

---
 rtl/int_to_float_iter.sv | 130 +++++++++++++
 tb/tb_int_to_float_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_iter.sv
// Iterative signed 32-bit integer to IEEE-754 single-precision converter.
// Normalizes the magnitude by left shifts (optionally 8 bits at a time while
// the top byte is clear), then rounds to nearest-even. One conversion in
// flight, valid/ready handshake on both sides.
module int_to_float_iter #(
  parameter bit MULTI_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] mag;
  logic [31:0] mag_next;
  logic [7:0]  exponent;
  logic [7:0]  exponent_next;
  logic        sign;
  logic        sign_next;
  logic [31:0] out_next;
  logic        inexact_next;

  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_sum;

  // Round-to-nearest-even on the normalized magnitude; bit 23 of the sum is the mantissa carry-out.
  always_comb begin
    guard    = mag[7];
    sticky   = |mag[6:0];
    round_up = guard & (sticky | mag[8]);
    frac_sum = {1'b0, mag[30:8]} + {23'd0, round_up};
  end

  // Next-state and datapath update: hold everything by default, act per state.
  always_comb begin
    state_next    = state;
    mag_next      = mag;
    exponent_next = exponent;
    sign_next     = sign;
    out_next      = out;
    inexact_next  = inexact;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_next     = in[31];
          // 0x80000000 negates to itself, which is the correct unsigned magnitude.
          mag_next      = in[31] ? (~in + 32'd1) : in;
          exponent_next = 8'd158;
          if (in == 32'd0) begin
            out_next     = 32'd0;
            inexact_next = 1'b0;
            state_next   = DONE;
          end else begin
            state_next   = NORM;
          end
        end else begin
          state_next = IDLE;
        end
      end
      NORM: begin
        if (mag[31]) begin
          state_next = ROUND;
        end else if (MULTI_SHIFT && (mag[31:24] == 8'd0)) begin
          mag_next      = {mag[23:0], 8'd0};
          exponent_next = exponent - 8'd8;
        end else begin
          mag_next      = {mag[30:0], 1'b0};
          exponent_next = exponent - 8'd1;
        end
      end
      ROUND: begin
        // A mantissa carry leaves frac_sum[22:0] at zero and bumps the exponent.
        exponent_next = exponent + {7'd0, frac_sum[23]};
        out_next      = {sign, exponent + {7'd0, frac_sum[23]}, frac_sum[22:0]};
        inexact_next  = guard | sticky;
        state_next    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; reset aborts any conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mag       <= 32'd0;
      exponent  <= 8'd0;
      sign      <= 1'b0;
      out       <= 32'd0;
      inexact   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      mag       <= mag_next;
      exponent  <= exponent_next;
      sign      <= sign_next;
      out       <= out_next;
      inexact   <= inexact_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_int_to_float_iter.sv
// Scoreboard bench for int_to_float_iter (MULTI_SHIFT=1): the driver pushes
// expected results at accept, a separate monitor checks latency when out_valid
// rises and checks out/inexact at each handover.
module tb_int_to_float_iter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        inexact;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] o;
    logic        ix;
    int          lat;
    int          e0;
  } exp_t;
  exp_t sbq[$];

  int_to_float_iter #(.MULTI_SHIFT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Independent reference: locate MSB, shift down, round half-to-even with integer compares.
  function automatic logic [32:0] ref_cvt(input logic [31:0] v);
    logic s;
    logic [31:0] m;
    int p;
    int e;
    int d;
    longint unsigned q, rem, half;
    logic ix;
    logic [7:0] e8;
    logic [22:0] f;
    s = v[31];
    m = s ? (~v + 32'd1) : v;
    if (m == 32'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p;
    ix = 1'b0;
    if (p <= 23) begin
      q = longint'(m) << (23 - p);
    end else begin
      d = p - 23;
      q = longint'(m) >> d;
      rem = longint'(m) & ((64'd1 << d) - 64'd1);
      half = 64'd1 << (d - 1);
      ix = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    e8 = e[7:0];
    f = q[22:0];
    return {ix, s, e8, f};
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    logic [31:0] m;
    int l;
    m = v[31] ? (~v + 32'd1) : v;
    if (m == 32'd0) return 0;
    l = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) break;
      l++;
    end
    return l / 8 + l % 8 + 2;
  endfunction

  // Monitor: latency on the rising edge of out_valid, result on each handover.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: out_valid with empty scoreboard");
        end else if (sbq[0].lat >= 0) begin
          check("latency", 32'(cyc - sbq[0].e0), 32'(sbq[0].lat));
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_handover: got 0x%08h expected none", dout);
        end else begin
          check("out", dout, sbq[0].o);
          check("inexact", {31'd0, inexact}, {31'd0, sbq[0].ix});
          void'(sbq.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Present an operand and push its expectation on the accept edge.
  task automatic send(input logic [31:0] v, input logic [31:0] eo, input logic ei, input int lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    din = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck low, expected high");
    end
    @(posedge clk); #1;
    e.o = eo; e.ix = ei; e.lat = lat; e.e0 = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall, then hand it over.
  task automatic drain(input int stall, input bit early);
    int n;
    out_ready = early;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: out_valid stuck low, expected high");
    end
    if (!early) repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic conv(input logic [31:0] v, input logic [31:0] eo, input logic ei, input int lat);
    send(v, eo, ei, lat);
    drain(0, 1'b0);
  endtask

  logic [32:0] r;
  logic [31:0] v;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    din = 32'd0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", dout, 32'd0);
    check("rst_inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    conv(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    conv(32'h0000_0001, 32'h3F80_0000, 1'b0, 12);
    conv(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 12);
    conv(32'h8000_0000, 32'hCF00_0000, 1'b0, 2);
    conv(32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3);
    conv(32'd16777217,  32'h4B80_0000, 1'b1, 9);
    conv(32'd16777219,  32'h4B80_0002, 1'b1, 9);

    // Backpressure: result held for 5 cycles while a new operand waits.
    send(32'd16777219, 32'h4B80_0002, 1'b1, 9);
    while (!out_valid) begin
      @(posedge clk); #1;
    end
    din = 32'd5;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_out", dout, 32'h4B80_0002);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_hold_out", dout, 32'h4B80_0002);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.o = 32'h40A0_0000; e.ix = 1'b0; e.lat = 10; e.e0 = cyc;
      sbq.push_back(e);
    end
    in_valid = 1'b0;
    check("bp_accepted", {31'd0, in_ready}, 32'd0);
    drain(0, 1'b0);

    // Reset pulse in the middle of normalization aborts the conversion.
    send(32'h0000_0001, 32'h3F80_0000, 1'b0, 12);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    sbq.delete();
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out", dout, 32'd0);
    check("abort_inexact", {31'd0, inexact}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    conv(32'd5, 32'h40A0_0000, 1'b0, 10);

    // Mixed operands (powers of two and neighbours, random) against the reference model.
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(31, 0);
      case (i % 6)
        0: v = 32'd1 << k;
        1: v = (32'd1 << k) + 32'd1;
        2: v = (32'd1 << k) - 32'd1;
        3: v = ~(32'd1 << k) + 32'd1;
        4: v = ~((32'd1 << k) + 32'd1) + 32'd1;
        default: v = $urandom;
      endcase
      r = ref_cvt(v);
      send(v, r[31:0], r[32], ref_lat(v));
      drain($urandom_range(3, 0), ($urandom_range(3, 0) == 0));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
